march_c_sequencer: RTL and testbench

- Self-contained March C- BIST sequencer for a single-port synchronous SRAM.
- Generates address order, write data, read strobes and expected data; compares read data; captures first failure.
- Sits between the test-access logic (start/abort, status) and the memory port mux.
- Replaces discrete counter/comparator glue with one sequencing block.

---
 rtl/bist_pkg.sv | 65 ++++++
 rtl/march_addr_gen.sv | 43 ++++
 rtl/march_c_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_march_c_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the March C- BIST sequencer:
//   - state_t   : sequencer FSM states (also exported on the debug port)
//   - elem_t    : march element index, E0..E5
//   - TBL_*     : per-element table, one bit per element (bit n = element n)
//   - elem_*()  : table accessors that tolerate out-of-range indices
// -----------------------------------------------------------------------------
package bist_pkg;

    localparam int NUM_ELEM = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef logic [2:0] elem_t;

    localparam elem_t E0 = 3'd0;  // up   : w0
    localparam elem_t E1 = 3'd1;  // up   : r0,w1
    localparam elem_t E2 = 3'd2;  // up   : r1,w0
    localparam elem_t E3 = 3'd3;  // down : r0,w1
    localparam elem_t E4 = 3'd4;  // down : r1,w0
    localparam elem_t E5 = 3'd5;  // up   : r0

    // Element table, bit n describes element n (E5 is the MSB).
    localparam logic [NUM_ELEM-1:0] TBL_UP        = 6'b100111;  // 1 = ascending
    localparam logic [NUM_ELEM-1:0] TBL_HAS_READ  = 6'b111110;
    localparam logic [NUM_ELEM-1:0] TBL_READ_EXP  = 6'b010100;  // 1 = expect all-ones
    localparam logic [NUM_ELEM-1:0] TBL_HAS_WRITE = 6'b011111;
    localparam logic [NUM_ELEM-1:0] TBL_WRITE_VAL = 6'b001010;  // 1 = write all-ones

    // Zero-extend to 8 entries so any 3-bit index is in range; unused
    // indices read as 0.
    function automatic logic tbl_bit(input logic [NUM_ELEM-1:0] tbl, input elem_t e);
        logic [7:0] w_ext;
        w_ext = 8'(tbl);
        return w_ext[e];
    endfunction

    function automatic logic elem_up(input elem_t e);
        return tbl_bit(TBL_UP, e);
    endfunction

    function automatic logic elem_has_read(input elem_t e);
        return tbl_bit(TBL_HAS_READ, e);
    endfunction

    function automatic logic elem_read_exp(input elem_t e);
        return tbl_bit(TBL_READ_EXP, e);
    endfunction

    function automatic logic elem_has_write(input elem_t e);
        return tbl_bit(TBL_HAS_WRITE, e);
    endfunction

    function automatic logic elem_write_val(input elem_t e);
        return tbl_bit(TBL_WRITE_VAL, e);
    endfunction

endpackage

// File: rtl/march_addr_gen.sv
// -----------------------------------------------------------------------------
// march_addr_gen
// Loadable up/down address counter for the march sequencer.
//   clk, rst      : clock, asynchronous active-high reset
//   i_load        : load start address; i_load_up picks 0 (up) or N-1 (down)
//                   and latches the counting direction
//   i_en          : step one address in the latched direction
//   o_addr        : current address (registered)
//   o_tc          : terminal count for the latched direction (N-1 up, 0 down)
// The direction is latched on load so o_tc never depends on the load decision
// of the same cycle.
// -----------------------------------------------------------------------------
module march_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_load_up,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_addr;
    logic              r_up;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_up   <= 1'b1;
        end else if (i_load) begin
            r_up   <= i_load_up;
            r_addr <= i_load_up ? '0 : '1;
        end else if (i_en) begin
            r_addr <= r_up ? (r_addr + ADDR_W'(1)) : (r_addr - ADDR_W'(1));
        end
    end

    assign o_addr = r_addr;
    assign o_tc   = r_up ? (r_addr == '1) : (r_addr == '0);

endmodule

// File: rtl/march_c_sequencer.sv
// -----------------------------------------------------------------------------
// march_c_sequencer
// March C- BIST sequencer for one single-port synchronous SRAM.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : level, accepted only in IDLE or DONE
//   abort      : level, stops a running test (RD/WR/FLUSH) on the next edge
//   mem_addr   : memory address       mem_we / mem_re : write / read strobe
//   mem_wdata  : write data           mem_rdata       : read data, 1 cycle after mem_re
//   busy       : test running         done / pass     : normal completion, result
//   fail       : sticky mismatch      fail_addr/elem  : first mismatch location
//   fail_cnt   : mismatch count (only with MARCH_FAIL_CNT_EN defined)
//   dbg_state  : current FSM state
// Memory interface: a strobe high in a cycle means the memory performs that
// op at mem_addr on the next rising edge; read data is compared one cycle
// after mem_re. Only one strobe is ever high.
// Optional macro: MARCH_FAIL_CNT_EN adds the saturating fail_cnt output.
// -----------------------------------------------------------------------------
module march_c_sequencer
    import bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
`ifdef MARCH_FAIL_CNT_EN
    output logic [ADDR_W+2:0] fail_cnt,
`endif
    output logic [2:0]        fail_elem,
    output state_t            dbg_state
);

    state_t            r_state;
    elem_t             r_elem;
    logic              r_busy, r_done, r_pass, r_fail;
    logic              r_mem_we, r_mem_re;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [ADDR_W-1:0] r_fail_addr;
    elem_t             r_fail_elem;
`ifdef MARCH_FAIL_CNT_EN
    logic [ADDR_W+2:0] r_fail_cnt;
`endif

    // Compare pipeline: captured on a read, checked one cycle later.
    logic              r_cmp_vld;
    logic              r_cmp_exp;
    logic [ADDR_W-1:0] r_cmp_addr;
    elem_t             r_cmp_elem;

    logic [ADDR_W-1:0] w_addr;
    logic              w_tc, w_load, w_load_up, w_en, w_mismatch, w_running;
    elem_t             w_nxt_elem;

    march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_load_up (w_load_up),
        .i_en      (w_en),
        .o_addr    (w_addr),
        .o_tc      (w_tc)
    );

    assign w_nxt_elem = r_elem + 3'd1;
    assign w_running  = (r_state == ST_RD) || (r_state == ST_WR) || (r_state == ST_FLUSH);
    assign w_mismatch = r_cmp_vld && (mem_rdata != {DATA_W{r_cmp_exp}});

    // Address control: the address only moves after the last op of an
    // element at the current address, and reloads at element boundaries.
    always_comb begin
        w_load    = 1'b0;
        w_load_up = 1'b1;
        w_en      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: w_load = start;
            ST_WR: begin
                if (!abort) begin
                    if (w_tc) begin
                        w_load    = 1'b1;
                        w_load_up = elem_up(w_nxt_elem);
                    end else begin
                        w_en = 1'b1;
                    end
                end
            end
            ST_RD: w_en = !abort && !elem_has_write(r_elem) && !w_tc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_elem      <= E0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_wdata <= '0;
            r_fail_addr <= '0;
            r_fail_elem <= E0;
            r_cmp_vld   <= 1'b0;
            r_cmp_exp   <= 1'b0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= E0;
`ifdef MARCH_FAIL_CNT_EN
            r_fail_cnt  <= '0;
`endif
        end else begin
            r_cmp_vld <= 1'b0;

            // Evaluated before the FSM so a compare still lands on an abort
            // edge or the FLUSH edge.
            if (w_mismatch) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= r_cmp_addr;
                    r_fail_elem <= r_cmp_elem;
                end
`ifdef MARCH_FAIL_CNT_EN
                if (r_fail_cnt != '1) begin
                    r_fail_cnt <= r_fail_cnt + (ADDR_W+3)'(1);
                end
`endif
            end

            if (abort && w_running) begin
                // A read issued in this cycle is dropped; capture registers stay.
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
                r_pass   <= 1'b0;
                r_mem_we <= 1'b0;
                r_mem_re <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            r_fail      <= 1'b0;
                            r_fail_addr <= '0;
                            r_fail_elem <= E0;
`ifdef MARCH_FAIL_CNT_EN
                            r_fail_cnt  <= '0;
`endif
                            r_done      <= 1'b0;
                            r_pass      <= 1'b0;
                            r_busy      <= 1'b1;
                            r_elem      <= E0;
                            r_state     <= ST_WR;
                            r_mem_we    <= 1'b1;
                            r_mem_re    <= 1'b0;
                            r_mem_wdata <= {DATA_W{elem_write_val(E0)}};
                        end
                    end
                    ST_WR: begin
                        if (w_tc) begin
                            r_elem <= w_nxt_elem;
                            if (elem_has_read(w_nxt_elem)) begin
                                r_state  <= ST_RD;
                                r_mem_we <= 1'b0;
                                r_mem_re <= 1'b1;
                            end else begin
                                r_mem_wdata <= {DATA_W{elem_write_val(w_nxt_elem)}};
                            end
                        end else if (elem_has_read(r_elem)) begin
                            r_state  <= ST_RD;
                            r_mem_we <= 1'b0;
                            r_mem_re <= 1'b1;
                        end
                    end
                    ST_RD: begin
                        r_cmp_vld  <= 1'b1;
                        r_cmp_exp  <= elem_read_exp(r_elem);
                        r_cmp_addr <= w_addr;
                        r_cmp_elem <= r_elem;
                        if (elem_has_write(r_elem)) begin
                            r_state     <= ST_WR;
                            r_mem_re    <= 1'b0;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= {DATA_W{elem_write_val(r_elem)}};
                        end else if (w_tc) begin
                            // Last read of the test; one cycle left for its compare.
                            r_state  <= ST_FLUSH;
                            r_mem_re <= 1'b0;
                        end
                    end
                    ST_FLUSH: begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !(r_fail || w_mismatch);
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_addr  = w_addr;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;
    assign dbg_state = r_state;
`ifdef MARCH_FAIL_CNT_EN
    assign fail_cnt  = r_fail_cnt;
`endif

endmodule

// File: tb/tb_march_c_sequencer.sv
// -----------------------------------------------------------------------------
// tb_march_c_sequencer
// Directed bench for march_c_sequencer (ADDR_W=4, DATA_W=8, N=16) with a
// behavioural SRAM that can inject a per-address stuck mask and a 3->2
// coupling fault.
// -----------------------------------------------------------------------------
module tb_march_c_sequencer;
    import bist_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst, start, abort;
    always #5 clk = ~clk;

    logic [AW-1:0] mem_addr, fail_addr;
    logic          mem_we, mem_re, busy, done, pass, fail;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [2:0]    fail_elem;
    state_t        dbg_state;
`ifdef MARCH_FAIL_CNT_EN
    logic [AW+2:0] fail_cnt;
`endif

    march_c_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .fail_addr (fail_addr),
`ifdef MARCH_FAIL_CNT_EN
        .fail_cnt  (fail_cnt),
`endif
        .fail_elem (fail_elem),
        .dbg_state (dbg_state)
    );

    // ---------------- memory model with fault injection ----------------
    logic [DW-1:0] mem [16];
    logic          flt_en  = 1'b0;
    logic [AW-1:0] flt_addr = '0;
    logic [DW-1:0] flt_or  = '0;
    logic [DW-1:0] flt_and = '1;
    logic          cpl_en  = 1'b0;

    initial mem_rdata = '0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            if (cpl_en && mem_addr == 4'd3 && mem_wdata == 8'hFF) mem[2] <= 8'hFF;
        end
        if (mem_re) begin
            if (flt_en && mem_addr == flt_addr) mem_rdata <= (mem[mem_addr] | flt_or) & flt_and;
            else                                mem_rdata <= mem[mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_mis = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    int   busy_n, e0_w, both_n;
    logic fail_c1, re_c17;
    logic [AW-1:0] addr_c17;
    logic [DW-1:0] wd_c18;

    // Raise start for 'hold' edges and follow the run until busy drops.
    // Cycle 1 is the first cycle after the accepting edge.
    task automatic run_full(input int hold);
        int c;
        got_q.delete();
        busy_n = 0; e0_w = 0; both_n = 0;
        start = 1'b1;
        @(negedge clk);
        c = 0;
        while (busy === 1'b1 && c < 1000) begin
            c++;
            if (c >= hold) start = 1'b0;
            if (c == 1) fail_c1 = fail;
            if (c <= 16 && mem_we) e0_w++;
            if (c == 17) begin re_c17 = mem_re; addr_c17 = mem_addr; end
            if (c == 18) wd_c18 = mem_wdata;
            if (c >= 81 && c <= 112 && mem_re) got_q.push_back(mem_addr);
            if (mem_we && mem_re) both_n++;
            @(negedge clk);
        end
        start = 1'b0;
        busy_n = c;
    endtask

    task automatic check_e3_order(input string tag);
        check({tag, "_e3_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_e3_addr"}, got_q[i], exp_q[i]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_we"},   mem_we, 0);
        check({tag, "_re"},   mem_re, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_faddr"}, fail_addr, 0);
        check({tag, "_felem"}, fail_elem, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int a = 15; a >= 0; a--) exp_q.push_back(AW'(a));
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fault-free run
        run_full(1);
        check("ideal_busy_cycles", busy_n, 161);
        check("ideal_done", done, 1);
        check("ideal_pass", pass, 1);
        check("ideal_fail", fail, 0);
        check("ideal_e0_writes", e0_w, 16);
        check("ideal_one_strobe", both_n, 0);
        check("ideal_e1_first_re", re_c17, 1);
        check("ideal_e1_first_addr", addr_c17, 0);
        check("ideal_e1_wdata", wd_c18, 8'hFF);
        check("ideal_state", dbg_state, ST_DONE);
        check_e3_order("ideal");
        repeat (3) @(negedge clk);
        check("done_held", done, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_done_done", done, 1);
        check("abort_in_done_pass", pass, 1);

        // Stuck-at-1 on bit 0 of address 5
        flt_en = 1'b1; flt_addr = 4'd5; flt_or = 8'h01; flt_and = 8'hFF;
        run_full(1);
        check("sa1_busy_cycles", busy_n, 161);
        check("sa1_done", done, 1);
        check("sa1_pass", pass, 0);
        check("sa1_fail", fail, 1);
        check("sa1_fail_addr", fail_addr, 5);
        check("sa1_fail_elem", fail_elem, 1);
`ifdef MARCH_FAIL_CNT_EN
        check("sa1_fail_cnt", fail_cnt, 3);
`endif

        // Coupling fault: writing ones to 3 forces 2 to ones
        flt_en = 1'b0; cpl_en = 1'b1;
        run_full(1);
        check("cpl_fail_cleared_on_start", fail_c1, 0);
        check("cpl_pass", pass, 0);
        check("cpl_fail_addr", fail_addr, 2);
        check("cpl_fail_elem", fail_elem, 3);
`ifdef MARCH_FAIL_CNT_EN
        check("cpl_fail_cnt", fail_cnt, 1);
`endif

        // Stuck-at-0 word at address 7
        cpl_en = 1'b0;
        flt_en = 1'b1; flt_addr = 4'd7; flt_or = 8'h00; flt_and = 8'h00;
        run_full(1);
        check("sa0_done", done, 1);
        check("sa0_pass", pass, 0);
        check("sa0_fail_addr", fail_addr, 7);
        check("sa0_fail_elem", fail_elem, 2);
`ifdef MARCH_FAIL_CNT_EN
        check("sa0_fail_cnt", fail_cnt, 2);
`endif
        flt_en = 1'b0;

        // Abort 40 cycles into a run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        check("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_we", mem_we, 0);
        check("abort_re", mem_re, 0);
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_fail", fail, 0);
        run_full(5);  // start held while busy must be ignored
        check("post_abort_busy_cycles", busy_n, 161);
        check("post_abort_pass", pass, 1);

        // Reset in the middle of E2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_full(1);
        check("post_rst_busy_cycles", busy_n, 161);
        check("post_rst_done", done, 1);
        check("post_rst_pass", pass, 1);
        check_e3_order("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
